// File: rtl/slave_in_port_pkg.sv
// Shared definitions for the serial system-bus slave ports.
// The state encoding is also used by the slave out-port.
package slave_in_port_pkg;

    localparam int BUS_ADDR_WIDTH = 12;
    localparam int BUS_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_ADDR = 2'd1,
        RX_DATA = 2'd2,
        DONE    = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } bus_op_e;

    // A request is only legal when exactly one of read/write is asserted.
    function automatic logic is_accept(input logic valid, input logic ready,
                                       input logic rd, input logic wr);
        return valid & ready & (rd ^ wr);
    endfunction

endpackage

// File: rtl/slave_in_port_serial_shift_reg.sv
// LSB-first serial capture register with bit counter and last-bit flag.
// Also supports an in-place increment used for burst address advance.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             inc,
    input  logic             serial_in,
    output logic [WIDTH-1:0] value,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CW'(i)) value_d[i] = serial_in;
            end
            cnt_d = cnt_q + CW'(1);
        end
        if (inc) value_d = value_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // High on the edge that captures the final bit of the field.
    assign last  = shift_en && (cnt_q == CW'(WIDTH - 1));
    assign value = value_q;

endmodule

// File: rtl/slave_in_port.sv
// Serial receive front-end of a bus slave: captures a serial address and
// optional data bytes (with burst continuation) and pulses rx_done per transfer.
module slave_in_port
    import slave_in_port_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_address,
    input  logic                  rx_data,
    input  logic                  master_valid,
    input  logic                  master_ready,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  rx_burst,
    output logic                  slave_ready,
    output logic                  rx_done,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data
);

    bus_state_e state_q, state_d;
    bus_op_e    op_q, op_d;
    logic       burst_q, burst_d;

    logic addr_clr, addr_shift, addr_inc, addr_last;
    logic data_clr, data_shift, data_last;

    serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
        .clk       (clk),
        .reset     (reset),
        .clr       (addr_clr),
        .shift_en  (addr_shift),
        .inc       (addr_inc),
        .serial_in (rx_address),
        .value     (address),
        .last      (addr_last)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
        .clk       (clk),
        .reset     (reset),
        .clr       (data_clr),
        .shift_en  (data_shift),
        .inc       (1'b0),
        .serial_in (rx_data),
        .value     (data),
        .last      (data_last)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        burst_d    = burst_q;
        addr_clr   = 1'b0;
        addr_shift = 1'b0;
        addr_inc   = 1'b0;
        data_clr   = 1'b0;
        data_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_accept(master_valid, master_ready, read_en, write_en)) begin
                    op_d     = write_en ? OP_WRITE : OP_READ;
                    burst_d  = 1'b0;
                    addr_clr = 1'b1;
                    state_d  = RX_ADDR;
                end
            end
            RX_ADDR: begin
                addr_shift = 1'b1;
                if (addr_last) begin
                    if (op_q == OP_WRITE) begin
                        data_clr = 1'b1;
                        state_d  = RX_DATA;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            RX_DATA: begin
                data_shift = 1'b1;
                if (data_last) begin
                    burst_d = rx_burst;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Serial lines are ignored here; a burst re-enters the data phase.
                if (op_q == OP_WRITE && burst_q) begin
                    addr_inc = 1'b1;
                    data_clr = 1'b1;
                    burst_d  = 1'b0;
                    state_d  = RX_DATA;
                end else begin
                    op_d    = OP_NONE;
                    burst_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            burst_q <= burst_d;
        end
    end

    assign slave_ready = (state_q == IDLE);
    assign rx_done     = (state_q == DONE);

endmodule

// File: tb/tb_slave_in_port.sv
// Directed, table-driven bench for slave_in_port with hand-computed expectations.
module tb_slave_in_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_address = 1'b0;
    logic        rx_data = 1'b0;
    logic        master_valid = 1'b0;
    logic        master_ready = 1'b0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic        rx_burst = 1'b0;
    logic        slave_ready;
    logic        rx_done;
    logic [11:0] address;
    logic [7:0]  data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic        ready;
        logic        rd;
        logic        wr;
        logic [11:0] a;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        burst;
        logic        acc;
        logic [11:0] ea0;
        logic [7:0]  ed0;
        logic [11:0] ea1;
        logic [7:0]  ed1;
    } vec_t;

    localparam int NVEC = 9;
    vec_t tbl [NVEC];
    vec_t post;

    slave_in_port dut (
        .clk          (clk),
        .reset        (reset),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .read_en      (read_en),
        .write_en     (write_en),
        .rx_burst     (rx_burst),
        .slave_ready  (slave_ready),
        .rx_done      (rx_done),
        .address      (address),
        .data         (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         nb;
        logic [7:0] d;
        logic       more;
        logic       early;
        early = 1'b0;
        @(negedge clk);
        master_valid = v.valid;
        master_ready = v.ready;
        read_en      = v.rd;
        write_en     = v.wr;
        @(negedge clk);
        master_valid = 1'b0;
        master_ready = 1'b0;
        read_en      = 1'b0;
        write_en     = 1'b0;
        if (!v.acc) begin
            repeat (3) begin
                chk("blocked_ready", 32'(slave_ready), 32'd1);
                chk("blocked_no_done", 32'(rx_done), 32'd0);
                @(negedge clk);
            end
            chk("blocked_addr_hold", 32'(address), 32'(v.ea0));
            chk("blocked_data_hold", 32'(data), 32'(v.ed0));
            return;
        end
        chk("busy_after_accept", 32'(slave_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            rx_address = v.a[i];
            rx_data    = 1'($urandom);
            rx_burst   = 1'($urandom);
            @(negedge clk);
            if (i < 11 && rx_done) early = 1'b1;
        end
        if (v.rd) begin
            chk("rd_done", 32'(rx_done), 32'd1);
            chk("rd_addr", 32'(address), 32'(v.ea0));
            chk("rd_data_hold", 32'(data), 32'(v.ed0));
        end else begin
            nb = v.burst ? 2 : 1;
            for (int b = 0; b < nb; b++) begin
                d    = (b == 0) ? v.d0 : v.d1;
                more = (b < nb - 1);
                if (b > 0) begin
                    // Junk on the DONE cycle must be ignored.
                    rx_data    = ~d[0];
                    rx_address = ~rx_address;
                    rx_burst   = 1'b1;
                    @(negedge clk);
                    if (rx_done) early = 1'b1;
                end
                for (int i = 0; i < 8; i++) begin
                    rx_data    = d[i];
                    rx_burst   = (i == 7) ? more : ~more;
                    rx_address = 1'($urandom);
                    @(negedge clk);
                    if (i < 7 && rx_done) early = 1'b1;
                end
                chk("wr_done", 32'(rx_done), 32'd1);
                chk("wr_addr", 32'(address), 32'((b == 0) ? v.ea0 : v.ea1));
                chk("wr_data", 32'(data), 32'((b == 0) ? v.ed0 : v.ed1));
            end
        end
        rx_burst   = 1'b0;
        rx_data    = 1'b0;
        rx_address = 1'b0;
        @(negedge clk);
        chk("ready_after_done", 32'(slave_ready), 32'd1);
        chk("done_one_cycle", 32'(rx_done), 32'd0);
        chk("no_early_done", 32'(early), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          vld  rdy  rd   wr   addr     d0     d1     bst  acc  ea0      ed0    ea1      ed1
        tbl[0] = '{1'b1,1'b1,1'b0,1'b1,12'hADD,8'hBD,8'h00,1'b0,1'b1,12'hADD,8'hBD,12'h000,8'h00};
        tbl[1] = '{1'b1,1'b1,1'b1,1'b0,12'h5A3,8'h00,8'h00,1'b0,1'b1,12'h5A3,8'hBD,12'h000,8'h00};
        tbl[2] = '{1'b1,1'b1,1'b0,1'b1,12'hFFF,8'h11,8'h22,1'b1,1'b1,12'hFFF,8'h11,12'h000,8'h22};
        tbl[3] = '{1'b1,1'b1,1'b1,1'b1,12'h123,8'h00,8'h00,1'b0,1'b0,12'h000,8'h22,12'h000,8'h00};
        tbl[4] = '{1'b1,1'b1,1'b0,1'b0,12'h123,8'h00,8'h00,1'b0,1'b0,12'h000,8'h22,12'h000,8'h00};
        tbl[5] = '{1'b1,1'b0,1'b0,1'b1,12'h123,8'h00,8'h00,1'b0,1'b0,12'h000,8'h22,12'h000,8'h00};
        tbl[6] = '{1'b0,1'b1,1'b1,1'b0,12'h123,8'h00,8'h00,1'b0,1'b0,12'h000,8'h22,12'h000,8'h00};
        tbl[7] = '{1'b1,1'b1,1'b0,1'b1,12'h801,8'h80,8'h00,1'b0,1'b1,12'h801,8'h80,12'h000,8'h00};
        tbl[8] = '{1'b1,1'b1,1'b1,1'b0,12'h000,8'h00,8'h00,1'b0,1'b1,12'h000,8'h80,12'h000,8'h00};
        post   = '{1'b1,1'b1,1'b0,1'b1,12'h3C5,8'h5A,8'h00,1'b0,1'b1,12'h3C5,8'h5A,12'h000,8'h00};

        // Reset held for two edges with random inputs.
        reset = 1'b0;
        repeat (2) begin
            master_valid = 1'($urandom);
            master_ready = 1'($urandom);
            read_en      = 1'($urandom);
            write_en     = 1'($urandom);
            rx_address   = 1'($urandom);
            rx_data      = 1'($urandom);
            rx_burst     = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_ready", 32'(slave_ready), 32'd1);
        chk("rst_done", 32'(rx_done), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        master_valid = 1'b0;
        master_ready = 1'b0;
        read_en      = 1'b0;
        write_en     = 1'b0;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
        rx_burst     = 1'b0;
        reset        = 1'b1;

        for (int k = 0; k < NVEC; k++) run_vec(tbl[k]);

        // Reset in the middle of the address phase after five bits.
        @(negedge clk);
        master_valid = 1'b1;
        master_ready = 1'b1;
        write_en     = 1'b1;
        @(negedge clk);
        master_valid = 1'b0;
        master_ready = 1'b0;
        write_en     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_address = 1'b1;
            @(negedge clk);
        end
        chk("mid_busy", 32'(slave_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(slave_ready), 32'd1);
        chk("mid_rst_done", 32'(rx_done), 32'd0);
        chk("mid_rst_addr", 32'(address), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        reset      = 1'b1;
        rx_address = 1'b0;
        @(negedge clk);
        chk("mid_idle_ready", 32'(slave_ready), 32'd1);
        chk("mid_idle_done", 32'(rx_done), 32'd0);
        run_vec(post);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slave_in_port.md
Name: slave_in_port

Overview:
Serial receive front-end of a system-bus slave. It accepts a bit-serial 12-bit address and, for writes, one or more bit-serial 8-bit data bytes from the master. It presents the assembled address and data in parallel to the slave memory/register logic and flags each completed transfer with rx_done. It sits between the bus interconnect (master side) and the slave's storage.

Parameters:
ADDR_WIDTH, 12, width of the address field and of the serial address phase (bits)
DATA_WIDTH, 8, width of one data byte and of each serial data phase (bits)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
rx_address  input  1  serial address line, LSB first
rx_data  input  1  serial data line, LSB first
master_valid  input  1  master requests a transaction
master_ready  input  1  master able to complete a transaction; required for acceptance
read_en  input  1  transaction is a read (address phase only)
write_en  input  1  transaction is a write (address + data phases)
rx_burst  input  1  burst continuation flag, sampled on the last data bit of each byte
slave_ready  output  1  slave idle and able to accept a new transaction
rx_done  output  1  one-cycle pulse: address (read) or address+byte (write) complete
address  output  ADDR_WIDTH  received address, registered
data  output  DATA_WIDTH  received data byte, registered

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-low: sampled on the rising edge of clk when low.
- Reset: state=IDLE, slave_ready=1, rx_done=0, address=0, data=0, bit counter=0, latched op=none. Reset mid-transaction aborts immediately with no rx_done.
- FSM states: IDLE, RX_ADDR, RX_DATA, DONE.
- IDLE: slave_ready=1.
  - Accept on an edge with master_valid=1 and master_ready=1 and exactly one of read_en/write_en high.
  - On accept: latch op (read/write), clear counter, go to RX_ADDR, slave_ready=0 from the next cycle.
  - No accept (including read_en=write_en=1 or both 0): stay in IDLE.
- RX_ADDR: on each of the next ADDR_WIDTH edges, sample rx_address into address[counter] (bit 0 first); counter increments.
  - After the 12th sample: write goes to RX_DATA (counter cleared); read goes to DONE.
- RX_DATA: on each of DATA_WIDTH edges, sample rx_data into data[counter] (bit 0 first).
  - On the 8th sample, rx_burst is also sampled; next state is DONE.
- DONE (one cycle): rx_done=1; address/data hold the complete values.
  - Write with burst flag set: go to RX_DATA, counter cleared; address increments by 1 on that transition, wrapping 12'hFFF to 12'h000.
  - Otherwise: return to IDLE (slave_ready=1 the following cycle).
- Timing: a write takes 1 (accept) + 12 + 8 + 1 cycles to rx_done; a read takes 1 + 12 + 1. Each burst byte adds 8 + 1 cycles.
- The DONE cycle is never a sampling cycle; serial lines are ignored there.
- master_valid, read_en and write_en are ignored after acceptance; deasserting master_valid does not abort.
- address/data change only while being shifted or incremented; otherwise hold the last value. data is untouched on reads.

Decomposition:
- Shared bus package: ADDR_WIDTH=12, DATA_WIDTH=8, and a state enum typedef (IDLE/RX_ADDR/RX_DATA/DONE) reused by the slave out-port.
- Natural sub-module: serial_shift_reg (parameterised width, LSB-first bit capture with counter and done flag), instantiated once for address and once for data.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> slave_ready=1, rx_done=0, address=0, data=0.
- Single write: valid=ready=write_en=1 for one accept edge, address stream 12'hADD LSB first, data 8'hBD LSB first, rx_burst=0 -> rx_done pulses on cycle 22 after accept; address=12'hADD, data=8'hBD; slave_ready=1 next cycle.
- Read: read_en=1, address 12'h5A3 -> rx_done on cycle 14; address=12'h5A3; data unchanged.
- Burst write: address 12'hFFF, bytes 8'h11, 8'h22 (rx_burst=1 on the last bit of byte 1, 0 on byte 2) -> two rx_done pulses 9 cycles apart with (FFF,11) then (000,22).
- Illegal or blocked request: read_en=write_en=1, or master_ready=0 -> stays IDLE, slave_ready=1, no rx_done.
- Reset mid-address phase after 5 bits -> IDLE, outputs cleared, no rx_done; a new write then completes normally.
